// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer width default and Gray/binary helpers
package fifo_pkg;

  localparam int ADDR_DEFAULT = 5;
  localparam int PTR_W_MAX    = 32;

  // Callers zero-extend narrower pointers; leading zeros leave the result unchanged.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - read-side FIFO pointer/flag bundle
interface fifo_rd_ctrl_if #(
  parameter int ADDR = fifo_pkg::ADDR_DEFAULT
) ();

  logic            rd_en;
  logic [ADDR:0]   wr_gray_async;
  logic [ADDR-1:0] rd_addr;
  logic [ADDR:0]   rd_gray;
  logic            empty;
  logic            almost_empty;
  logic [ADDR:0]   rd_level;
  logic            underflow;

  modport master (
    output rd_en, wr_gray_async,
    input  rd_addr, rd_gray, empty, almost_empty, rd_level, underflow
  );

  modport slave (
    input  rd_en, wr_gray_async,
    output rd_addr, rd_gray, empty, almost_empty, rd_level, underflow
  );

endinterface

// File: rtl/fifo_rd_ctrl_sync_2ff.sv
// rtl/fifo_rd_ctrl_sync_2ff.sv - two-flop synchronizer, nothing between the flops
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read pointer, empty/level flags, underflow
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR      = fifo_pkg::ADDR_DEFAULT,
  parameter int AE_THRESH = 2
) (
  input logic           clk,
  input logic           reset_b,
  fifo_rd_ctrl_if.slave bus
);

  localparam logic [ADDR:0] AE_LVL = (ADDR+1)'(AE_THRESH);

  logic [ADDR:0] r_rd_bin;
  logic [ADDR:0] r_rd_gray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [ADDR:0] r_rd_level;
  logic          r_underflow;

  logic [ADDR:0] w_wr_gray_s2;
  logic [ADDR:0] w_wr_bin_s;
  logic          w_rd_fire;
  logic [ADDR:0] w_rd_bin_next;
  logic [ADDR:0] w_rd_gray_next;
  logic [ADDR:0] w_level_next;

  sync_2ff #(
    .WIDTH (ADDR + 1)
  ) u_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .d       (bus.wr_gray_async),
    .q       (w_wr_gray_s2)
  );

  assign w_wr_bin_s     = (ADDR+1)'(gray2bin(PTR_W_MAX'(w_wr_gray_s2)));
  assign w_rd_fire      = bus.rd_en & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + {{ADDR{1'b0}}, w_rd_fire};
  assign w_rd_gray_next = (ADDR+1)'(bin2gray(PTR_W_MAX'(w_rd_bin_next)));
  // Flags use the post-read pointer so the last read raises empty on the same edge.
  assign w_level_next   = w_wr_bin_s - w_rd_bin_next;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_rd_bin       <= '0;
      r_rd_gray      <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_level     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_rd_bin       <= w_rd_bin_next;
      r_rd_gray      <= w_rd_gray_next;
      r_empty        <= (w_rd_gray_next == w_wr_gray_s2);
      r_almost_empty <= (w_level_next <= AE_LVL);
      r_rd_level     <= w_level_next;
      r_underflow    <= r_underflow | (bus.rd_en & r_empty);
    end
  end

  assign bus.rd_addr      = r_rd_bin[ADDR-1:0];
  assign bus.rd_gray      = r_rd_gray;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.rd_level     = r_rd_level;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  localparam int ADDR = 5;

  logic clk;
  logic reset_b;
  int   n_checks;
  int   n_fail;

  fifo_rd_ctrl_if #(.ADDR(ADDR)) bus ();

  fifo_rd_ctrl #(
    .ADDR      (ADDR),
    .AE_THRESH (2)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_gray"}, 32'(bus.rd_gray), 32'h0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
    check({tag, "_empty"}, 32'(bus.empty), 32'h1);
    check({tag, "_almost_empty"}, 32'(bus.almost_empty), 32'h1);
    check({tag, "_rd_level"}, 32'(bus.rd_level), 32'h0);
    check({tag, "_underflow"}, 32'(bus.underflow), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset asserted with random inputs, checked before any clock edge.
    reset_b = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_gray_async = '0;
    #1;
    reset_b = 1'b0;
    bus.rd_en = 1'($urandom_range(0, 1));
    bus.wr_gray_async = 6'($urandom);
    #2;
    check_reset_vals("rst0");
    bus.rd_en = 1'b0;
    bus.wr_gray_async = '0;
    tick(2);
    reset_b = 1'b1;
    tick(2);

    // Single entry: 0 -> 1, two-cycle sync plus one flag register.
    bus.wr_gray_async = 6'h01;
    tick(2);
    check("single_latency_empty", 32'(bus.empty), 32'h1);
    tick(1);
    check("single_empty", 32'(bus.empty), 32'h0);
    check("single_level", 32'(bus.rd_level), 32'h1);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("single_rd_empty", 32'(bus.empty), 32'h1);
    check("single_rd_level", 32'(bus.rd_level), 32'h0);
    check("single_rd_addr", 32'(bus.rd_addr), 32'h1);
    check("single_rd_gray", 32'(bus.rd_gray), 32'h1);
    check("single_no_uflow", 32'(bus.underflow), 32'h0);

    // Underflow: read while empty, pointer holds, flag sticks.
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("uflow_gray_hold", 32'(bus.rd_gray), 32'h1);
    check("uflow_set", 32'(bus.underflow), 32'h1);
    tick(10);
    check("uflow_sticky", 32'(bus.underflow), 32'h1);
    check("uflow_addr_hold", 32'(bus.rd_addr), 32'h1);

    reset_b = 1'b0;
    bus.wr_gray_async = '0;
    tick(2);
    reset_b = 1'b1;
    tick(1);
    check("rst1_underflow", 32'(bus.underflow), 32'h0);

    // Full: binary 32 is Gray 0x30.
    bus.wr_gray_async = 6'h30;
    tick(3);
    check("full_level", 32'(bus.rd_level), 32'd32);
    check("full_ae", 32'(bus.almost_empty), 32'h0);
    check("full_empty", 32'(bus.empty), 32'h0);
    bus.rd_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      if (k == 32) bus.rd_en = 1'b0;
      check($sformatf("drain_level_%0d", k), 32'(bus.rd_level), 32'(32 - k));
      check($sformatf("drain_empty_%0d", k), 32'(bus.empty), (k == 32) ? 32'h1 : 32'h0);
    end
    check("drain_gray", 32'(bus.rd_gray), 32'h30);
    check("drain_addr", 32'(bus.rd_addr), 32'h0);
    check("drain_ae", 32'(bus.almost_empty), 32'h1);
    check("drain_no_uflow", 32'(bus.underflow), 32'h0);

    // Threshold: write binary 35 (Gray 0x32), read pointer at 32.
    bus.wr_gray_async = 6'h32;
    tick(3);
    check("thr_level3", 32'(bus.rd_level), 32'd3);
    check("thr_ae_off", 32'(bus.almost_empty), 32'h0);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("thr_level2", 32'(bus.rd_level), 32'd2);
    check("thr_ae_on", 32'(bus.almost_empty), 32'h1);
    check("thr_addr", 32'(bus.rd_addr), 32'h1);
    check("thr_gray", 32'(bus.rd_gray), 32'h31);

    // Pointer wrap 63 -> 0: write binary 65 mod 64 = 1 (Gray 0x01), read at 33.
    bus.wr_gray_async = 6'h01;
    tick(3);
    check("wrap_level_full", 32'(bus.rd_level), 32'd32);
    bus.rd_en = 1'b1;
    tick(32);
    bus.rd_en = 1'b0;
    check("wrap_gray", 32'(bus.rd_gray), 32'h01);
    check("wrap_addr", 32'(bus.rd_addr), 32'h01);
    check("wrap_empty", 32'(bus.empty), 32'h1);
    check("wrap_level", 32'(bus.rd_level), 32'h0);
    check("wrap_no_uflow", 32'(bus.underflow), 32'h0);

    // Mid-operation reset: write binary 11 (Gray 0x0E), read pointer at 1.
    bus.wr_gray_async = 6'h0E;
    tick(3);
    check("mid_level10", 32'(bus.rd_level), 32'd10);
    bus.rd_en = 1'b1;
    tick(1);
    check("mid_level9", 32'(bus.rd_level), 32'd9);
    #2;
    reset_b = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    bus.rd_en = 1'b0;
    tick(2);
    reset_b = 1'b1;
    tick(3);
    check("post_rst_level", 32'(bus.rd_level), 32'd11);
    check("post_rst_empty", 32'(bus.empty), 32'h0);
    bus.rd_en = 1'b1;
    check("post_rst_first_addr", 32'(bus.rd_addr), 32'h0);
    tick(1);
    bus.rd_en = 1'b0;
    check("post_rst_next_addr", 32'(bus.rd_addr), 32'h1);
    check("post_rst_level10", 32'(bus.rd_level), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 5, meaning address width; depth is 2^ADDR and pointers are ADDR+1 bits.
REQ-002 SHALL have parameter AE_THRESH, default 2, meaning almost_empty asserts at level <= AE_THRESH.
REQ-003 SHALL have port clk, input, 1, read-domain clock.
REQ-004 SHALL have port reset_b, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rd_en, input, 1, read request.
REQ-006 SHALL have port wr_gray_async, input, ADDR+1, write-domain Gray pointer, asynchronous to clk.
REQ-007 SHALL have port rd_addr, output, ADDR, RAM read address, equal to rd_bin[ADDR-1:0].
REQ-008 SHALL have port rd_gray, output, ADDR+1, registered read Gray pointer for the write domain.
REQ-009 SHALL have port empty, output, 1, registered empty flag.
REQ-010 SHALL have port almost_empty, output, 1, registered flag.
REQ-011 SHALL have port rd_level, output, ADDR+1, registered occupancy as seen from the read domain, range 0..2^ADDR.
REQ-012 SHALL have port underflow, output, 1, sticky read-while-empty error.

Function
REQ-013 SHALL pass wr_gray_async through two flops, s1 then s2, both resetting to 0; no logic SHALL sit between the flops.
REQ-014 SHALL convert s2 to binary wr_bin_s by prefix XOR from the MSB down.
REQ-015 SHALL accept a read only when rd_fire = rd_en & ~empty.
REQ-016 SHALL compute rd_bin_next = rd_bin + rd_fire, modulo 2^(ADDR+1), wrapping from all-ones to 0.
REQ-017 SHALL compute rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next.
REQ-018 SHALL register rd_bin <= rd_bin_next and rd_gray <= rd_gray_next every clk; exactly one rd_gray bit changes per accepted read.
REQ-019 SHALL register empty <= (rd_gray_next == s2), comparing all ADDR+1 bits.
REQ-020 SHALL register rd_level <= (wr_bin_s - rd_bin_next) modulo 2^(ADDR+1); MSB wrap SHALL make level 2^ADDR (full) distinct from 0.
REQ-021 SHALL register almost_empty <= (level_next <= AE_THRESH).
REQ-022 SHALL set underflow on any edge with rd_en=1 and empty=1, and SHALL hold it until reset; in that case the pointers SHALL NOT move.
REQ-023 SHALL meet this latency: a write-pointer change sampled into s1 at edge N reaches s2 at N+1, and empty/rd_level update at N+2.
REQ-024 SHALL, on an accepted read, assert empty at the same edge the last entry is consumed, with no added latency.
REQ-025 SHALL compute flags from the next-state values when a read and a sync update occur in the same cycle; no read SHALL be lost or double-counted.
REQ-026 Flags SHALL be conservative only: a stale synchronized pointer can delay empty deassertion but SHALL NOT cause a false non-empty.

Reset
REQ-027 SHALL, while reset_b=0 and without a clock, force rd_bin=0, rd_gray=0, rd_addr=0, s1=s2=0, empty=1, almost_empty=1, rd_level=0, underflow=0.
REQ-028 SHALL honour reset asserted mid-operation immediately; the first accepted read after release SHALL use address 0.

Structure
REQ-029 SHALL place the ADDR default and the gray2bin/bin2gray functions in shared package fifo_pkg, for reuse by the write-side pointer logic.
REQ-030 SHALL implement the synchronizer as sub-module sync_2ff (parameter WIDTH, ports clk, reset_b, d, q).
REQ-031 SHALL contain no combinational path from wr_gray_async to any output.

Verification
REQ-032 Reset: reset_b=0 with random inputs -> rd_gray=0, rd_addr=0, empty=1, almost_empty=1, rd_level=0, underflow=0 before any clk edge.
REQ-033 Single entry: wr_gray_async 0->1 sampled at edge N -> empty=0, rd_level=1 after N+2; rd_en for 1 cycle -> empty=1, rd_level=0, rd_addr=1, rd_gray=1.
REQ-034 Underflow: rd_en=1 while empty -> rd_gray unchanged, underflow=1, still 1 after 10 idle cycles.
REQ-035 Full and wrap: wr_gray_async=0x30 (binary 32), rd_bin=0 -> rd_level=32, almost_empty=0; 32 consecutive reads -> rd_gray=0x30, rd_addr=0, empty=1, rd_level=0.
REQ-036 Threshold: rd_level=3 -> almost_empty=0; one read -> rd_level=2, almost_empty=1.
REQ-037 Mid-operation reset: rd_level=10 and rd_en=1, then reset_b low between edges -> all outputs at reset values asynchronously; first read after release uses rd_addr=0.
